// File: rtl/_page_dezigzag_rowdist.sv
// Zigzag-to-raster reorder of 8x8 coefficient blocks through a two-bank ping-pong store.
// Each completed block leaves as eight row beats, column K on lane K, all lanes in lockstep.
module _page_dezigzag_rowdist #(
  parameter int W     = 16,
  parameter bit ZZ_EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] c_d,
  input  logic         c_e,
  input  logic         c_v,
  output logic         c_b,
  output logic [W-1:0] r0_d,
  output logic [W-1:0] r1_d,
  output logic [W-1:0] r2_d,
  output logic [W-1:0] r3_d,
  output logic [W-1:0] r4_d,
  output logic [W-1:0] r5_d,
  output logic [W-1:0] r6_d,
  output logic [W-1:0] r7_d,
  output logic         r0_e,
  output logic         r1_e,
  output logic         r2_e,
  output logic         r3_e,
  output logic         r4_e,
  output logic         r5_e,
  output logic         r6_e,
  output logic         r7_e,
  output logic         r0_v,
  output logic         r1_v,
  output logic         r2_v,
  output logic         r3_v,
  output logic         r4_v,
  output logic         r5_v,
  output logic         r6_v,
  output logic         r7_v,
  input  logic         r0_b,
  input  logic         r1_b,
  input  logic         r2_b,
  input  logic         r3_b,
  input  logic         r4_b,
  input  logic         r5_b,
  input  logic         r6_b,
  input  logic         r7_b,
  output logic         blk_err
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_EMIT} state_t;

  // Zigzag position -> raster index (row*8 + column)
  function automatic logic [5:0] zz(input logic [5:0] n);
    case (n)
      6'd0:  zz = 6'd0;   6'd1:  zz = 6'd1;   6'd2:  zz = 6'd8;   6'd3:  zz = 6'd16;
      6'd4:  zz = 6'd9;   6'd5:  zz = 6'd2;   6'd6:  zz = 6'd3;   6'd7:  zz = 6'd10;
      6'd8:  zz = 6'd17;  6'd9:  zz = 6'd24;  6'd10: zz = 6'd32;  6'd11: zz = 6'd25;
      6'd12: zz = 6'd18;  6'd13: zz = 6'd11;  6'd14: zz = 6'd4;   6'd15: zz = 6'd5;
      6'd16: zz = 6'd12;  6'd17: zz = 6'd19;  6'd18: zz = 6'd26;  6'd19: zz = 6'd33;
      6'd20: zz = 6'd40;  6'd21: zz = 6'd48;  6'd22: zz = 6'd41;  6'd23: zz = 6'd34;
      6'd24: zz = 6'd27;  6'd25: zz = 6'd20;  6'd26: zz = 6'd13;  6'd27: zz = 6'd6;
      6'd28: zz = 6'd7;   6'd29: zz = 6'd14;  6'd30: zz = 6'd21;  6'd31: zz = 6'd28;
      6'd32: zz = 6'd35;  6'd33: zz = 6'd42;  6'd34: zz = 6'd49;  6'd35: zz = 6'd56;
      6'd36: zz = 6'd57;  6'd37: zz = 6'd50;  6'd38: zz = 6'd43;  6'd39: zz = 6'd36;
      6'd40: zz = 6'd29;  6'd41: zz = 6'd22;  6'd42: zz = 6'd15;  6'd43: zz = 6'd23;
      6'd44: zz = 6'd30;  6'd45: zz = 6'd37;  6'd46: zz = 6'd44;  6'd47: zz = 6'd51;
      6'd48: zz = 6'd58;  6'd49: zz = 6'd59;  6'd50: zz = 6'd52;  6'd51: zz = 6'd45;
      6'd52: zz = 6'd38;  6'd53: zz = 6'd31;  6'd54: zz = 6'd39;  6'd55: zz = 6'd46;
      6'd56: zz = 6'd53;  6'd57: zz = 6'd60;  6'd58: zz = 6'd61;  6'd59: zz = 6'd54;
      6'd60: zz = 6'd47;  6'd61: zz = 6'd55;  6'd62: zz = 6'd62;  6'd63: zz = 6'd63;
      default: zz = n;
    endcase
  endfunction

  state_t       state_reg;
  logic [1:0]   full_reg;
  logic [1:0]   full_next;
  logic         wb_reg;
  logic         rb_reg;
  logic [5:0]   wc_reg;
  logic [2:0]   rr_reg;
  logic         out_v_reg;
  logic         out_e_reg;
  logic         blk_err_reg;

  logic [7:0]   lane_b;
  logic [W-1:0] lane_d [8];
  logic         accept;
  logic         accept_data;
  logic         accept_eos;
  logic         beat_xfer;
  logic         load;
  logic [5:0]   wr_idx;
  logic [2:0]   wr_row;
  logic [2:0]   wr_col;

  assign lane_b = {r7_b, r6_b, r5_b, r4_b, r3_b, r2_b, r1_b, r0_b};

  // Stall depends only on registers so the upstream never sees a combinational loop
  assign c_b         = full_reg[wb_reg] | (state_reg != ST_RUN);
  assign accept      = c_v & ~c_b;
  assign accept_data = accept & ~c_e;
  assign accept_eos  = accept & c_e;

  assign beat_xfer   = out_v_reg & ~(|lane_b);
  assign load        = (~out_v_reg | beat_xfer) & full_reg[rb_reg];

  assign wr_idx      = ZZ_EN ? zz(wc_reg) : wc_reg;
  assign wr_row      = wr_idx[5:3];
  assign wr_col      = wr_idx[2:0];

  // Fill and drain always target different banks, so both edits can apply together
  always_comb begin
    full_next = full_reg;
    if (accept_data && wc_reg == 6'd63) full_next[wb_reg] = 1'b1;
    if (load && rr_reg == 3'd7)         full_next[rb_reg] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      full_reg    <= 2'b00;
      wb_reg      <= 1'b0;
      rb_reg      <= 1'b0;
      wc_reg      <= 6'd0;
      rr_reg      <= 3'd0;
      out_v_reg   <= 1'b0;
      out_e_reg   <= 1'b0;
      blk_err_reg <= 1'b0;
    end else begin
      full_reg <= full_next;

      if (accept_data) begin
        wc_reg <= wc_reg + 6'd1;
        if (wc_reg == 6'd63) wb_reg <= ~wb_reg;
      end

      if (load) begin
        rr_reg <= rr_reg + 3'd1;
        if (rr_reg == 3'd7) rb_reg <= ~rb_reg;
      end

      if (load) begin
        out_v_reg <= 1'b1;
      end else if (beat_xfer) begin
        out_v_reg <= 1'b0;
        out_e_reg <= 1'b0;
      end

      case (state_reg)
        ST_RUN: begin
          if (accept_eos) begin
            // A partial block is dropped by rewinding the fill count
            if (wc_reg != 6'd0) blk_err_reg <= 1'b1;
            wc_reg    <= 6'd0;
            state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (full_reg == 2'b00 && !out_v_reg) begin
            out_v_reg <= 1'b1;
            out_e_reg <= 1'b1;
            state_reg <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (beat_xfer) state_reg <= ST_RUN;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // One small RAM per column lane lets a whole row be read in a single cycle
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [W-1:0] lane_mem [0:15];
    logic [W-1:0] lane_d_reg;

    always_ff @(posedge clock) begin
      if (reset && accept_data && wr_col == 3'(gi))
        lane_mem[{wb_reg, wr_row}] <= c_d;
    end

    always_ff @(posedge clock) begin
      if (!reset)    lane_d_reg <= '0;
      else if (load) lane_d_reg <= lane_mem[{rb_reg, rr_reg}];
    end

    assign lane_d[gi] = lane_d_reg;
  end

  assign r0_d = lane_d[0];
  assign r1_d = lane_d[1];
  assign r2_d = lane_d[2];
  assign r3_d = lane_d[3];
  assign r4_d = lane_d[4];
  assign r5_d = lane_d[5];
  assign r6_d = lane_d[6];
  assign r7_d = lane_d[7];

  assign r0_v = out_v_reg;
  assign r1_v = out_v_reg;
  assign r2_v = out_v_reg;
  assign r3_v = out_v_reg;
  assign r4_v = out_v_reg;
  assign r5_v = out_v_reg;
  assign r6_v = out_v_reg;
  assign r7_v = out_v_reg;

  assign r0_e = out_e_reg;
  assign r1_e = out_e_reg;
  assign r2_e = out_e_reg;
  assign r3_e = out_e_reg;
  assign r4_e = out_e_reg;
  assign r5_e = out_e_reg;
  assign r6_e = out_e_reg;
  assign r7_e = out_e_reg;

  assign blk_err = blk_err_reg;

endmodule

// File: tb/tb__page_dezigzag_rowdist.sv
// Directed bench for the zigzag row distributor: reorder, lane stall, full banks,
// end-of-stream handling and reset while a beat is held.
module tb__page_dezigzag_rowdist;
  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic [W-1:0] c_d;
  logic         c_e;
  logic         c_v;
  logic         c_b;
  logic [W-1:0] rd [8];
  logic [7:0]   re;
  logic [7:0]   rv;
  logic [7:0]   rb_bus;
  logic         blk_err;

  int errors = 0;
  int checks = 0;

  // Raster index found at each zigzag position
  int zz_tab [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [8*W-1:0] obs_d [$];
  logic [7:0]     obs_v [$];
  logic [7:0]     obs_e [$];

  _page_dezigzag_rowdist #(.W(W), .ZZ_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .c_d(c_d), .c_e(c_e), .c_v(c_v), .c_b(c_b),
    .r0_d(rd[0]), .r1_d(rd[1]), .r2_d(rd[2]), .r3_d(rd[3]),
    .r4_d(rd[4]), .r5_d(rd[5]), .r6_d(rd[6]), .r7_d(rd[7]),
    .r0_e(re[0]), .r1_e(re[1]), .r2_e(re[2]), .r3_e(re[3]),
    .r4_e(re[4]), .r5_e(re[5]), .r6_e(re[6]), .r7_e(re[7]),
    .r0_v(rv[0]), .r1_v(rv[1]), .r2_v(rv[2]), .r3_v(rv[3]),
    .r4_v(rv[4]), .r5_v(rv[5]), .r6_v(rv[6]), .r7_v(rv[7]),
    .r0_b(rb_bus[0]), .r1_b(rb_bus[1]), .r2_b(rb_bus[2]), .r3_b(rb_bus[3]),
    .r4_b(rb_bus[4]), .r5_b(rb_bus[5]), .r6_b(rb_bus[6]), .r7_b(rb_bus[7]),
    .blk_err(blk_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one token and hold it until accepted (bounded)
  task automatic send(input logic [W-1:0] d, input logic e, output int waited);
    c_d = d; c_e = e; c_v = 1'b1; waited = 0;
    while (c_b && waited < 300) begin
      @(posedge clock); #1;
      waited++;
    end
    @(posedge clock); #1;
    c_v = 1'b0; c_e = 1'b0;
  endtask

  // Record beats; only used while the outputs are never stalled
  task automatic capture(input int n, input int budget, input bit include_now);
    int cyc;
    logic [8*W-1:0] row;
    cyc = 0;
    obs_d.delete(); obs_v.delete(); obs_e.delete();
    if (include_now && rv[0]) begin
      for (int k = 0; k < 8; k++) row[k*W +: W] = rd[k];
      obs_d.push_back(row); obs_v.push_back(rv); obs_e.push_back(re);
      $display("beat %0d: v=%h e=%h lane0=%0d lane7=%0d", obs_d.size(), rv, re, rd[0], rd[7]);
    end
    while (obs_d.size() < n && cyc < budget) begin
      @(posedge clock); #1;
      cyc++;
      if (rv[0]) begin
        for (int k = 0; k < 8; k++) row[k*W +: W] = rd[k];
        obs_d.push_back(row); obs_v.push_back(rv); obs_e.push_back(re);
        $display("beat %0d: v=%h e=%h lane0=%0d lane7=%0d", obs_d.size(), rv, re, rd[0], rd[7]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; c_v = 1'b0; c_e = 1'b0; c_d = '0; rb_bus = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL reset_v: got %h expected 00", rv); end
    checks++; if (re !== 8'h00) begin errors++; $display("FAIL reset_e: got %h expected 00", re); end
    checks++; if (c_b !== 1'b0) begin errors++; $display("FAIL reset_cb: got %b expected 0", c_b); end
    checks++; if (blk_err !== 1'b0) begin errors++; $display("FAIL reset_blkerr: got %b expected 0", blk_err); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd[k] !== '0) begin errors++; $display("FAIL reset_d lane%0d: got %0d expected 0", k, rd[k]); end
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reorder();
    int w, wsum;
    wsum = 0;
    rb_bus = 8'h00;
    for (int n = 0; n < 64; n++) begin
      send(W'(zz_tab[n]), 1'b0, w);
      wsum += w;
    end
    checks++; if (wsum != 0) begin errors++; $display("FAIL t1_stall: got %0d stall cycles expected 0", wsum); end
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL t1_early: got v=%h expected 00", rv); end
    for (int j = 0; j < 8; j++) begin
      @(posedge clock); #1;
      $display("t1 beat %0d: v=%h lane0=%0d lane7=%0d", j, rv, rd[0], rd[7]);
      checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL t1_v beat%0d: got %h expected ff", j, rv); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== W'(8*j + k)) begin
          errors++; $display("FAIL t1_d beat%0d lane%0d: got %0d expected %0d", j, k, rd[k], 8*j + k);
        end
      end
    end
    @(posedge clock); #1;
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL t1_extra: got v=%h expected 00", rv); end
  endtask

  task automatic test_lane_stall();
    int w;
    rb_bus = 8'h00;
    for (int n = 0; n < 64; n++) send(W'(100 + zz_tab[n]), 1'b0, w);
    repeat (3) @(posedge clock);
    #1;
    rb_bus[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      $display("t2 stall %0d: v=%h lane0=%0d lane3=%0d", c, rv, rd[0], rd[3]);
      checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL t2_hold_v cyc%0d: got %h expected ff", c, rv); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== W'(100 + 16 + k)) begin
          errors++; $display("FAIL t2_hold_d cyc%0d lane%0d: got %0d expected %0d", c, k, rd[k], 116 + k);
        end
      end
    end
    rb_bus[3] = 1'b0;
    for (int j = 3; j < 8; j++) begin
      @(posedge clock); #1;
      $display("t2 beat %0d: v=%h lane0=%0d", j, rv, rd[0]);
      checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL t2_v beat%0d: got %h expected ff", j, rv); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== W'(100 + 8*j + k)) begin
          errors++; $display("FAIL t2_d beat%0d lane%0d: got %0d expected %0d", j, k, rd[k], 100 + 8*j + k);
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full();
    int w, wsum, tmo;
    logic [8*W-1:0] row;
    wsum = 0; tmo = 0;
    rb_bus = 8'hFF;
    for (int n = 0; n < 128; n++) begin
      send(W'(1000 + 64*(n/64) + zz_tab[n%64]), 1'b0, w);
      wsum += w;
    end
    checks++; if (wsum != 0) begin errors++; $display("FAIL t3_early_stall: got %0d stall cycles expected 0", wsum); end
    checks++; if (c_b !== 1'b1) begin errors++; $display("FAIL t3_cb_128: got %b expected 1", c_b); end
    checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL t3_row0_v: got %h expected ff", rv); end
    checks++; if (rd[5] !== W'(1005)) begin errors++; $display("FAIL t3_row0_d: got %0d expected 1005", rd[5]); end
    c_d = W'(1128); c_e = 1'b0; c_v = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checks++; if (c_b !== 1'b1) begin errors++; $display("FAIL t3_cb_hold: got %b expected 1", c_b); end
    fork
      begin
        for (int n = 128; n < 192; n++) begin
          send(W'(1000 + 128 + zz_tab[n%64]), 1'b0, w);
          if (w >= 300) tmo++;
        end
      end
      begin
        rb_bus = 8'h00;
        capture(24, 300, 1'b1);
      end
    join
    checks++; if (tmo != 0) begin errors++; $display("FAIL t3_send_timeout: got %0d timeouts expected 0", tmo); end
    checks++; if (obs_d.size() != 24) begin errors++; $display("FAIL t3_count: got %0d beats expected 24", obs_d.size()); end
    for (int j = 0; j < obs_d.size() && j < 24; j++) begin
      row = obs_d[j];
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (row[k*W +: W] !== W'(1000 + 8*j + k)) begin
          errors++; $display("FAIL t3_d beat%0d lane%0d: got %0d expected %0d", j, k, row[k*W +: W], 1000 + 8*j + k);
        end
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_eos_clean();
    int w, extra;
    logic [8*W-1:0] row;
    extra = 0;
    rb_bus = 8'h00;
    fork
      begin
        for (int n = 0; n < 64; n++) send(W'(2000 + zz_tab[n]), 1'b0, w);
        send('0, 1'b1, w);
      end
      capture(9, 200, 1'b0);
    join
    checks++; if (obs_d.size() != 9) begin errors++; $display("FAIL t4_count: got %0d beats expected 9", obs_d.size()); end
    for (int j = 0; j < obs_d.size() && j < 9; j++) begin
      row = obs_d[j];
      checks++; if (obs_v[j] !== 8'hFF) begin errors++; $display("FAIL t4_v beat%0d: got %h expected ff", j, obs_v[j]); end
      checks++;
      if (obs_e[j] !== ((j == 8) ? 8'hFF : 8'h00)) begin
        errors++; $display("FAIL t4_e beat%0d: got %h expected %h", j, obs_e[j], (j == 8) ? 8'hFF : 8'h00);
      end
      if (j < 8) begin
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (row[k*W +: W] !== W'(2000 + 8*j + k)) begin
            errors++; $display("FAIL t4_d beat%0d lane%0d: got %0d expected %0d", j, k, row[k*W +: W], 2000 + 8*j + k);
          end
        end
      end
    end
    repeat (10) begin
      @(posedge clock); #1;
      if (rv !== 8'h00) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL t4_extra: got %0d extra valid cycles expected 0", extra); end
    checks++; if (blk_err !== 1'b0) begin errors++; $display("FAIL t4_blkerr: got %b expected 0", blk_err); end
    checks++; if (c_b !== 1'b0) begin errors++; $display("FAIL t4_cb: got %b expected 0", c_b); end
  endtask

  task automatic test_eos_mid();
    int w;
    rb_bus = 8'h00;
    fork
      begin
        for (int n = 0; n < 10; n++) send(W'(n), 1'b0, w);
        send('0, 1'b1, w);
      end
      capture(2, 60, 1'b0);
    join
    checks++; if (obs_d.size() != 1) begin errors++; $display("FAIL t5_count: got %0d beats expected 1", obs_d.size()); end
    if (obs_d.size() >= 1) begin
      checks++; if (obs_e[0] !== 8'hFF) begin errors++; $display("FAIL t5_e: got %h expected ff", obs_e[0]); end
      checks++; if (obs_v[0] !== 8'hFF) begin errors++; $display("FAIL t5_v: got %h expected ff", obs_v[0]); end
    end
    checks++; if (blk_err !== 1'b1) begin errors++; $display("FAIL t5_blkerr: got %b expected 1", blk_err); end
    repeat (20) @(posedge clock);
    #1;
    checks++; if (blk_err !== 1'b1) begin errors++; $display("FAIL t5_blkerr_sticky: got %b expected 1", blk_err); end
    checks++; if (c_b !== 1'b0) begin errors++; $display("FAIL t5_cb: got %b expected 0", c_b); end
  endtask

  task automatic test_reset_mid_beat();
    int w, extra;
    logic [8*W-1:0] row;
    extra = 0;
    rb_bus = 8'h00;
    for (int n = 0; n < 64; n++) send(W'(3000 + zz_tab[n]), 1'b0, w);
    repeat (5) @(posedge clock);
    #1;
    rb_bus = 8'hFF;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL t6_held_v: got %h expected ff", rv); end
    checks++; if (rd[2] !== W'(3034)) begin errors++; $display("FAIL t6_held_d: got %0d expected 3034", rd[2]); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL t6_rst_v: got %h expected 00", rv); end
    checks++; if (re !== 8'h00) begin errors++; $display("FAIL t6_rst_e: got %h expected 00", re); end
    checks++; if (c_b !== 1'b0) begin errors++; $display("FAIL t6_rst_cb: got %b expected 0", c_b); end
    checks++; if (blk_err !== 1'b0) begin errors++; $display("FAIL t6_rst_blkerr: got %b expected 0", blk_err); end
    reset = 1'b1;
    rb_bus = 8'h00;
    fork
      begin
        for (int n = 0; n < 64; n++) send(W'(4000 + zz_tab[n]), 1'b0, w);
      end
      capture(9, 150, 1'b0);
    join
    checks++; if (obs_d.size() != 8) begin errors++; $display("FAIL t6_count: got %0d beats expected 8", obs_d.size()); end
    for (int j = 0; j < obs_d.size() && j < 8; j++) begin
      row = obs_d[j];
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (row[k*W +: W] !== W'(4000 + 8*j + k)) begin
          errors++; $display("FAIL t6_d beat%0d lane%0d: got %0d expected %0d", j, k, row[k*W +: W], 4000 + 8*j + k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_lane_stall();
    test_full();
    test_eos_clean();
    test_eos_mid();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
